// File: rtl/sobel_pkg.sv
// Shared types and helpers for the Sobel stream controller: FSM state encoding,
// pixel payload layout and counter sizing.
package sobel_pkg;

  localparam int DATA_W_DEF = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ctrl_state_e;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] r;
    logic [DATA_W_DEF-1:0] g;
    logic [DATA_W_DEF-1:0] b;
  } pix_t;

  // Width of a counter spanning 0..n-1; a dimension of 1 still needs one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic is_active(input ctrl_state_e s);
    return (s == RUN) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/sobel_stream_ctrl_if.sv
// Pixel-in, filter-drive and result-out bundle of the Sobel stream controller.
// The slave modport is the controller's view; master is the surrounding system.
interface sobel_stream_ctrl_if
  import sobel_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_r;
  logic [DATA_W-1:0] s_g;
  logic [DATA_W-1:0] s_b;

  logic [DATA_W-1:0] f_r;
  logic [DATA_W-1:0] f_g;
  logic [DATA_W-1:0] f_b;
  logic [DATA_W-1:0] f_y;

  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_y;
  logic              m_sof;
  logic              m_eol;

  modport master (
    output s_valid, s_r, s_g, s_b, m_ready, f_y,
    input  s_ready, f_r, f_g, f_b, m_valid, m_y, m_sof, m_eol
  );

  modport slave (
    input  s_valid, s_r, s_g, s_b, m_ready, f_y,
    output s_ready, f_r, f_g, f_b, m_valid, m_y, m_sof, m_eol
  );

endinterface

// File: rtl/sobel_pipe_reg.sv
// Single valid/ready register slice with full throughput; the payload holds its
// last value whenever the slice is empty or stalled.
module sobel_pipe_reg
  import sobel_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q;
  logic         valid_d;
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;
  logic         load;

  // Accepting while the current word leaves is what keeps one word per cycle.
  always_comb begin
    in_ready = !valid_q || out_ready;
    load     = in_valid && in_ready;
    valid_d  = valid_q;
    data_d   = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/sobel_stream_ctrl.sv
// Frame controller: walks a raster RGB stream through an external sobel_filter,
// tagging each result with start-of-frame and end-of-line markers.
module sobel_stream_ctrl
  import sobel_pkg::*;
#(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  sobel_stream_ctrl_if.slave bus
);

  localparam int COL_W = cnt_w(IMG_W);
  localparam int ROW_W = cnt_w(IMG_H);
  localparam int PW1   = 3 * DATA_W + 2;
  localparam int PW2   = DATA_W + 2;

  ctrl_state_e      state_q;
  ctrl_state_e      state_d;
  logic             busy_q;
  logic             busy_d;
  logic             done_q;
  logic             done_d;
  logic [COL_W-1:0] col_q;
  logic [COL_W-1:0] col_d;
  logic [ROW_W-1:0] row_q;
  logic [ROW_W-1:0] row_d;

  logic             run;
  logic             s_ready_int;
  logic             accept;
  logic             last_col;
  logic             last_row;
  logic             tag_sof;
  logic             tag_eol;

  logic             s1_in_ready;
  logic             s1_valid;
  logic             s2_in_ready;
  logic [PW1-1:0]   s1_in_data;
  logic [PW1-1:0]   s1_data;
  logic [PW2-1:0]   s2_in_data;
  logic [PW2-1:0]   s2_data;

  assign run         = (state_q == RUN);
  assign s_ready_int = run && s1_in_ready;
  assign accept      = bus.s_valid && s_ready_int;
  assign bus.s_ready = s_ready_int;

  assign last_col = (col_q == COL_W'(IMG_W - 1));
  assign last_row = (row_q == ROW_W'(IMG_H - 1));
  assign tag_sof  = (col_q == '0) && (row_q == '0);
  assign tag_eol  = last_col;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          col_d   = '0;
          row_d   = '0;
        end
      end
      RUN: begin
        if (accept) begin
          if (last_col) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
            if (last_row) begin
              state_d = DRAIN;
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      // Finish once S1 is empty and S2 is empty or handing off its last word now.
      DRAIN: begin
        if (!s1_valid && (!bus.m_valid || bus.m_ready)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = is_active(state_d);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  // S1: pixel and tags; its payload is the registered drive into the filter.
  assign s1_in_data = {bus.s_r, bus.s_g, bus.s_b, tag_sof, tag_eol};

  sobel_pipe_reg #(.W(PW1)) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.s_valid && run),
    .in_ready  (s1_in_ready),
    .in_data   (s1_in_data),
    .out_valid (s1_valid),
    .out_ready (s2_in_ready),
    .out_data  (s1_data)
  );

  assign {bus.f_r, bus.f_g, bus.f_b} = s1_data[PW1-1:2];

  // S2: filter result captured alongside the tags that travelled with the pixel.
  assign s2_in_data = {bus.f_y, s1_data[1:0]};

  sobel_pipe_reg #(.W(PW2)) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s2_in_ready),
    .in_data   (s2_in_data),
    .out_valid (bus.m_valid),
    .out_ready (bus.m_ready),
    .out_data  (s2_data)
  );

  assign {bus.m_y, bus.m_sof, bus.m_eol} = s2_data;

endmodule

// File: tb/tb_sobel_stream_ctrl.sv
// Bench for sobel_stream_ctrl on a 4x2 frame with a luma-style stand-in for the
// external filter: table-driven pixels, scoreboard on the output stream.
module tb_sobel_stream_ctrl;
  import sobel_pkg::*;

  localparam int IMG_W = 4;
  localparam int IMG_H = 2;
  localparam int DW    = 10;
  localparam int NPIX  = IMG_W * IMG_H;

  typedef struct packed {
    pix_t          pix;
    logic [DW-1:0] y;
    logic          sof;
    logic          eol;
  } vec_t;

  typedef struct packed {
    logic [DW-1:0] y;
    logic          sof;
    logic          eol;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy;
  logic done;
  logic [11:0] fsum;

  sobel_stream_ctrl_if #(.DATA_W(DW)) bus ();

  sobel_stream_ctrl #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .DATA_W (DW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Filter stand-in: y = (r + 2g + b) / 4, combinational from the f_* drive.
  always_comb begin
    fsum     = {2'b00, bus.f_r} + {1'b0, bus.f_g, 1'b0} + {2'b00, bus.f_b};
    bus.f_y  = fsum[11:2];
  end

  vec_t tbl [NPIX];
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int first_acc, first_mv, out_cnt, done_cnt, done_cyc, last_out;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic set_vec(input int idx, input int r, input int g, input int b, input int y);
    tbl[idx].pix.r = DW'(r);
    tbl[idx].pix.g = DW'(g);
    tbl[idx].pix.b = DW'(b);
    tbl[idx].y     = DW'(y);
    tbl[idx].sof   = (idx == 0);
    tbl[idx].eol   = ((idx % IMG_W) == IMG_W - 1);
  endtask

  function automatic logic [63:0] outs_vec();
    return 64'({busy, done, bus.s_ready, bus.m_valid, bus.m_sof, bus.m_eol,
                bus.f_r, bus.f_g, bus.f_b, bus.m_y});
  endfunction

  // Output monitor: every presented result is checked against the scoreboard head.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (bus.s_valid && bus.s_ready && first_acc < 0) first_acc = cyc;
      if (bus.m_valid) begin
        if (first_mv < 0) first_mv = cyc;
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL scoreboard_underflow: got result %0h required none (cycle %0d)", bus.m_y, cyc);
        end else begin
          chk("m_y", 64'(bus.m_y), 64'(sb[0].y));
          chk("m_sof", 64'(bus.m_sof), 64'(sb[0].sof));
          chk("m_eol", 64'(bus.m_eol), 64'(sb[0].eol));
          if (bus.m_ready) begin
            void'(sb.pop_front());
            out_cnt++;
            last_out = cyc;
            $display("result %0d: m_y=%0h sof=%0b eol=%0b", out_cnt - 1, bus.m_y, bus.m_sof, bus.m_eol);
          end
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic clear_stats();
    first_acc = -1;
    first_mv  = -1;
    out_cnt   = 0;
    done_cnt  = 0;
    done_cyc  = -1;
    last_out  = -1;
  endtask

  task automatic send(input int idx, input bit bubble, input bit pulse_start);
    bit   ok;
    exp_t e;
    ok            = 1'b0;
    bus.s_valid   = 1'b1;
    bus.s_r       = tbl[idx].pix.r;
    bus.s_g       = tbl[idx].pix.g;
    bus.s_b       = tbl[idx].pix.b;
    if (pulse_start) start = 1'b1;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      if (bus.s_ready) begin
        ok    = 1'b1;
        e.y   = tbl[idx].y;
        e.sof = tbl[idx].sof;
        e.eol = tbl[idx].eol;
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: pixel %0d not accepted within 40 cycles", idx);
    end
    if (bubble) begin
      bus.s_valid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic stall();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 60 && !ok; t++) begin
      @(negedge clk);
      if (out_cnt >= 2) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL stall_wait: got %0d results required 2 within 60 cycles", out_cnt);
    end
    @(posedge clk);
    #1;
    bus.m_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k >= 1) chk("s_ready_stall", 64'(bus.s_ready), 64'(0));
      chk("m_valid_stall", 64'(bus.m_valid), 64'(1));
    end
    @(posedge clk);
    #1;
    bus.m_ready = 1'b1;
  endtask

  // mode: 0 streaming, 1 bubbles, 2 backpressure, 3 start pulsed mid-frame
  task automatic run_frame(input int mode);
    clear_stats();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'(1));
    chk("s_ready_after_start", 64'(bus.s_ready), 64'(1));
    fork
      for (int i = 0; i < NPIX; i++) send(i, mode == 1, (mode == 3) && (i == 2));
      if (mode == 2) stall();
    join
    bus.s_valid = 1'b0;
    for (int t = 0; t < 100 && done_cnt == 0; t++) @(negedge clk);
    if (done_cnt == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: mode %0d got no done within 100 cycles", mode);
    end
    repeat (3) @(negedge clk);
    chk("out_count", 64'(out_cnt), 64'(NPIX));
    chk("scoreboard_empty", 64'(sb.size()), 64'(0));
    chk("done_pulses", 64'(done_cnt), 64'(1));
    chk("done_after_last", 64'(done_cyc), 64'(last_out + 1));
    chk("first_latency", 64'(first_mv - first_acc), 64'(2));
    chk("busy_after_done", 64'(busy), 64'(0));
    chk("f_hold_last", 64'({bus.f_r, bus.f_g, bus.f_b}), 64'(tbl[NPIX-1].pix));
    $display("frame mode %0d: %0d results, done at cycle %0d", mode, out_cnt, done_cyc);
  endtask

  initial begin
    set_vec(0,    0,    0,    0,    0);
    set_vec(1, 1023, 1023, 1023, 1023);
    set_vec(2,  100,  200,  300,  200);
    set_vec(3,    4,    0,    0,    1);
    set_vec(4,    3,    0,    0,    0);
    set_vec(5,  512,  256,    0,  256);
    set_vec(6,    1,    1,    2,    1);
    set_vec(7, 1000,   10,   20,  260);

    clear_stats();
    bus.s_valid = 1'b0;
    bus.s_r     = '0;
    bus.s_g     = '0;
    bus.s_b     = '0;
    bus.m_ready = 1'b1;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs_vec(), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    bus.s_valid = 1'b1;
    bus.s_r     = 10'h155;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("s_ready_no_start", 64'(bus.s_ready), 64'(0));
      chk("m_valid_idle", 64'(bus.m_valid), 64'(0));
    end
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;

    run_frame(0);
    run_frame(2);
    run_frame(1);
    run_frame(3);

    // Reset after pixel 3 is accepted: everything clears and no done appears.
    clear_stats();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) send(i, 1'b0, 1'b0);
    rst_n = 1'b0;
    bus.s_valid = 1'b0;
    #1;
    chk("async_reset_outputs", outs_vec(), 64'(0));
    sb.delete();
    repeat (2) @(negedge clk);
    chk("reset_hold_outputs", outs_vec(), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("no_done_after_reset", 64'(done_cnt), 64'(0));
    chk("idle_after_reset", 64'(busy), 64'(0));

    run_frame(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
